// File: rtl/i2c_ctrl.sv
// I2C single-byte master: random write/read with 8- or 16-bit register address.
// Define I2C_NACK_ABORT_EN to end the transfer with STOP when the slave NACKs.
module i2c_ctrl #(
  parameter logic [6:0]  DEVICE_ADDR  = 7'b1010_000,
  parameter logic [25:0] SYS_CLK_FREQ = 26'd50_000_000,
  parameter logic [17:0] SCL_FREQ     = 18'd250_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        i2c_start,
  input  logic        addr_num,
  input  logic [15:0] byte_addr,
  input  logic [7:0]  wr_data,
  output logic        i2c_clk,
  output logic        i2c_end,
  output logic [7:0]  rd_data,
  output logic        i2c_scl,
  inout  wire         i2c_sda
);

  localparam int CNT_CLK_MAX = int'((SYS_CLK_FREQ / SCL_FREQ) >> 3);
  localparam int CW = $clog2(CNT_CLK_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, START_1, SEND_D_ADDR, ACK_1,
    SEND_B_ADDR_H, ACK_2, SEND_B_ADDR_L, ACK_3,
    WR_DATA, ACK_4, START_2, SEND_RD_ADDR,
    ACK_5, RD_DATA, N_ACK, STOP
  } state_t;

  logic [CW-1:0] cnt_clk;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_clk <= '0;
      i2c_clk <= 1'b1;
    end else if (cnt_clk == CW'(CNT_CLK_MAX - 1)) begin
      cnt_clk <= '0;
      i2c_clk <= ~i2c_clk;
    end else begin
      cnt_clk <= cnt_clk + CW'(1);
    end
  end

  state_t     state, state_nxt;
  logic [1:0] cnt_i2c_clk, cnt_nxt;
  logic [2:0] cnt_bit, bit_nxt;
  logic       sda_en, sda_out;
  logic [7:0] rd_shift;
  logic       is_byte, last, abort;
  logic       st_start, st_tx;
  logic       scl_nxt, sda_en_nxt, sda_out_nxt;
  logic [7:0] tx_byte;

`ifdef I2C_NACK_ABORT_EN
  logic ack;
  assign abort = ack;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    is_byte = state inside {SEND_D_ADDR, SEND_B_ADDR_H,
      SEND_B_ADDR_L, WR_DATA, SEND_RD_ADDR, RD_DATA};
    last = (cnt_i2c_clk == 2'd3) &&
           (!is_byte || cnt_bit == 3'd7);
    cnt_nxt = cnt_i2c_clk + 2'd1;
    bit_nxt = cnt_bit;
    if (is_byte && cnt_i2c_clk == 2'd3)
      bit_nxt = cnt_bit + 3'd1;
    state_nxt = state;
    if (last) begin
      case (state)
        IDLE:          if (i2c_start) state_nxt = START_1;
        START_1:       state_nxt = SEND_D_ADDR;
        SEND_D_ADDR:   state_nxt = ACK_1;
        ACK_1:         state_nxt = abort ? STOP :
                         (addr_num ? SEND_B_ADDR_H : SEND_B_ADDR_L);
        SEND_B_ADDR_H: state_nxt = ACK_2;
        ACK_2:         state_nxt = abort ? STOP : SEND_B_ADDR_L;
        SEND_B_ADDR_L: state_nxt = ACK_3;
        ACK_3:         state_nxt = abort ? STOP :
                         wr_en ? WR_DATA :
                         rd_en ? START_2 : STOP;
        WR_DATA:       state_nxt = ACK_4;
        ACK_4:         state_nxt = STOP;
        START_2:       state_nxt = SEND_RD_ADDR;
        SEND_RD_ADDR:  state_nxt = ACK_5;
        ACK_5:         state_nxt = abort ? STOP : RD_DATA;
        RD_DATA:       state_nxt = N_ACK;
        N_ACK:         state_nxt = STOP;
        default:       state_nxt = IDLE;
      endcase
    end
  end

  // Pins are decoded from the next state so the registered outputs line up with cnt.
  always_comb begin
    case (state_nxt)
      SEND_D_ADDR:   tx_byte = {DEVICE_ADDR, 1'b0};
      SEND_B_ADDR_H: tx_byte = byte_addr[15:8];
      SEND_B_ADDR_L: tx_byte = byte_addr[7:0];
      WR_DATA:       tx_byte = wr_data;
      SEND_RD_ADDR:  tx_byte = {DEVICE_ADDR, 1'b1};
      default:       tx_byte = 8'h00;
    endcase
    st_start = state_nxt inside {START_1, START_2};
    st_tx = state_nxt inside {SEND_D_ADDR, SEND_B_ADDR_H,
      SEND_B_ADDR_L, WR_DATA, SEND_RD_ADDR};
    scl_nxt     = 1'b1;
    sda_en_nxt  = 1'b1;
    sda_out_nxt = 1'b1;
    unique case (1'b1)
      state_nxt == IDLE: sda_en_nxt = 1'b0;
      st_start: sda_out_nxt = (cnt_nxt == 2'd0);
      state_nxt == STOP: begin
        scl_nxt     = (cnt_nxt != 2'd0);
        sda_out_nxt = cnt_nxt[1];
      end
      st_tx: begin
        scl_nxt     = cnt_nxt[1] ^ cnt_nxt[0];
        sda_out_nxt = tx_byte[~bit_nxt];
      end
      default: begin
        scl_nxt    = cnt_nxt[1] ^ cnt_nxt[0];
        sda_en_nxt = (state_nxt == N_ACK);
      end
    endcase
  end

  always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      cnt_i2c_clk <= 2'd0;
      cnt_bit     <= 3'd0;
      i2c_scl     <= 1'b1;
      sda_en      <= 1'b0;
      sda_out     <= 1'b1;
      i2c_end     <= 1'b0;
      rd_data     <= 8'h00;
      rd_shift    <= 8'h00;
`ifdef I2C_NACK_ABORT_EN
      ack         <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt_i2c_clk <= cnt_nxt;
      cnt_bit     <= bit_nxt;
      i2c_scl     <= scl_nxt;
      sda_en      <= sda_en_nxt;
      sda_out     <= sda_out_nxt;
      i2c_end     <= (state_nxt == STOP) && (cnt_nxt == 2'd3);
      if (state == RD_DATA && cnt_i2c_clk == 2'd2)
        rd_shift <= {rd_shift[6:0], i2c_sda};
      if (state == RD_DATA && cnt_i2c_clk == 2'd3 &&
          cnt_bit == 3'd7)
        rd_data <= rd_shift;
`ifdef I2C_NACK_ABORT_EN
      if (cnt_i2c_clk == 2'd1 &&
          state inside {ACK_1, ACK_2, ACK_3, ACK_4, ACK_5})
        ack <= i2c_sda;
`endif
    end
  end

  assign i2c_sda = sda_en ? sda_out : 1'bz;

endmodule

// File: tb/tb_i2c_ctrl.sv
// Directed bench for i2c_ctrl: bus monitor plus a simple EEPROM-like slave.
// Time unit is arbitrary; sys_clk period is 20 units (one 50 MHz cycle).
module tb_i2c_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        i2c_start = 1'b0;
  logic        addr_num = 1'b0;
  logic [15:0] byte_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;
  logic        i2c_clk, i2c_end, i2c_scl;
  logic [7:0]  rd_data;
  wire         i2c_sda;

  logic        sl_bit = 1'b1;
  logic        nack_mode = 1'b0;
  logic [7:0]  rd_val = 8'h00;

  int n_cmp = 0;
  int n_mis = 0;

  i2c_ctrl #(.DEVICE_ADDR(7'h78)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wr_en(wr_en), .rd_en(rd_en),
    .i2c_start(i2c_start), .addr_num(addr_num),
    .byte_addr(byte_addr), .wr_data(wr_data),
    .i2c_clk(i2c_clk), .i2c_end(i2c_end),
    .rd_data(rd_data), .i2c_scl(i2c_scl),
    .i2c_sda(i2c_sda)
  );

  // Slave drive doubles as the pull-up whenever the master lets go.
  assign i2c_sda = dut.sda_en ? 1'bz : sl_bit;

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_end = 1'b0;
  logic       scl_s, sda_s;
  logic [7:0] shreg = 8'h00;
  logic [7:0] byte_q[$];
  logic       ack_q[$];
  int         bitcnt = 0, n_start = 0, n_stop = 0;
  int         n_end = 0, end_w = 0;
  int         clr_req = 0, clr_seen = 0;
  logic       first_byte = 1'b0, rd_pend = 1'b0, slave_tx = 1'b0;
  time        t_start = 0, t_end = 0, t_rise = 0, scl_per = 0;

  always @(negedge sys_clk) begin
    if (clr_req != clr_seen) begin
      byte_q.delete();
      ack_q.delete();
      n_start = 0; n_stop = 0; n_end = 0; end_w = 0;
      bitcnt = 0; slave_tx = 1'b0; rd_pend = 1'b0;
      first_byte = 1'b0;
      clr_seen = clr_req;
    end
    scl_s = i2c_scl;
    sda_s = i2c_sda;
    if (prev_scl && scl_s && prev_sda && !sda_s) begin
      n_start++;
      t_start = $time;
      bitcnt = 0; shreg = 8'h00;
      first_byte = 1'b1; slave_tx = 1'b0;
    end
    if (prev_scl && scl_s && !prev_sda && sda_s)
      n_stop++;
    if (!prev_scl && scl_s) begin
      if (bitcnt == 3) scl_per = $time - t_rise;
      t_rise = $time;
      if (bitcnt < 8) begin
        shreg = {shreg[6:0], sda_s};
        bitcnt++;
        if (bitcnt == 8) begin
          byte_q.push_back(shreg);
          if (first_byte && shreg[0]) rd_pend = 1'b1;
          first_byte = 1'b0;
        end
      end else begin
        ack_q.push_back(sda_s);
        bitcnt = 0;
        if (slave_tx) slave_tx = 1'b0;
        else if (rd_pend) begin
          slave_tx = 1'b1;
          rd_pend = 1'b0;
        end
      end
    end
    if (prev_scl && !scl_s) begin
      if (slave_tx && bitcnt < 8) sl_bit = rd_val[7-bitcnt];
      else if (!slave_tx && bitcnt == 8) sl_bit = nack_mode;
      else sl_bit = 1'b1;
    end
    if (i2c_end && !prev_end) begin
      n_end++;
      t_end = $time;
    end
    if (i2c_end) end_w++;
    prev_scl = scl_s;
    prev_sda = sda_s;
    prev_end = i2c_end;
  end

  task automatic mon_clear();
    clr_req++;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic wait_end(input string tag);
    int k;
    k = 0;
    while (!i2c_end && k < 12000) begin
      @(negedge sys_clk);
      k++;
    end
    chk(tag, {31'd0, i2c_end}, 32'd1);
  endtask

  task automatic chk_bus(input string pfx,
                         input logic [7:0] eb[4],
                         input logic ea[4]);
    chk({pfx, "_nbytes"}, byte_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_byte%0d", pfx, i),
          (i < byte_q.size()) ? {24'd0, byte_q[i]} : 32'hDEAD,
          {24'd0, eb[i]});
      chk($sformatf("%s_ack%0d", pfx, i),
          (i < ack_q.size()) ? {31'd0, ack_q[i]} : 32'hDEAD,
          {31'd0, ea[i]});
    end
  endtask

  logic [7:0] exp_wr[4] = '{8'hF0, 8'hFF, 8'hFF, 8'hAA};
  logic       ack_wr[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0] exp_rd[4] = '{8'hF0, 8'h12, 8'hF1, 8'h5A};
  logic       ack_rd[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  time        t0;
  int         k;

  initial begin
    #95;
    chk("rst_i2c_clk", {31'd0, i2c_clk}, 32'd1);
    chk("rst_scl", {31'd0, i2c_scl}, 32'd1);
    chk("rst_sda_rel", {31'd0, dut.sda_en}, 32'd0);
    chk("rst_end", {31'd0, i2c_end}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_state", {28'd0, dut.state}, 32'd0);
    sys_rst_n = 1'b1;

    repeat (1000) @(negedge sys_clk);
    chk("idle_state", {28'd0, dut.state}, 32'd0);
    chk("idle_scl", {31'd0, i2c_scl}, 32'd1);
    chk("idle_sda_rel", {31'd0, dut.sda_en}, 32'd0);
    chk("idle_starts", n_start, 32'd0);

    @(posedge i2c_clk);
    t0 = $time;
    @(posedge i2c_clk);
    chk("i2c_clk_period", 32'(($time - t0) / 20), 32'd50);

    mon_clear();
    wr_en = 1'b1; rd_en = 1'b0; addr_num = 1'b1;
    byte_addr = 16'hFFFF; wr_data = 8'hAA;
    i2c_start = 1'b1;
    wait_end("wr_end_seen");
    i2c_start = 1'b0;
    repeat (500) @(negedge sys_clk);
    chk_bus("wr", exp_wr, ack_wr);
    chk("wr_starts", n_start, 32'd1);
    chk("wr_stops", n_stop, 32'd1);
    chk("wr_end_pulses", n_end, 32'd1);
    chk("wr_end_width", end_w, 32'd50);
    // SDA falls at START_1 cnt1; i2c_end rises 150 us later at STOP cnt3.
    chk("wr_latency", 32'((t_end - t_start) / 20), 32'd7500);
    chk("scl_period", 32'(scl_per / 20), 32'd200);
    chk("wr_idle_state", {28'd0, dut.state}, 32'd0);

    mon_clear();
    wr_en = 1'b0; rd_en = 1'b1; addr_num = 1'b0;
    byte_addr = 16'h0012; rd_val = 8'h5A;
    i2c_start = 1'b1;
    wait_end("rd_end_seen");
    i2c_start = 1'b0;
    chk("rd_data_at_end", {24'd0, rd_data}, 32'h5A);
    repeat (500) @(negedge sys_clk);
    chk_bus("rd", exp_rd, ack_rd);
    chk("rd_starts", n_start, 32'd2);
    chk("rd_stops", n_stop, 32'd1);
    chk("rd_end_pulses", n_end, 32'd1);
    chk("rd_data_held", {24'd0, rd_data}, 32'h5A);

`ifdef I2C_NACK_ABORT_EN
    mon_clear();
    nack_mode = 1'b1;
    wr_en = 1'b1; rd_en = 1'b0; addr_num = 1'b1;
    byte_addr = 16'h1234; wr_data = 8'h77;
    i2c_start = 1'b1;
    wait_end("nack_end_seen");
    i2c_start = 1'b0;
    repeat (500) @(negedge sys_clk);
    chk("nack_nbytes", byte_q.size(), 32'd1);
    chk("nack_byte0",
        (byte_q.size() > 0) ? {24'd0, byte_q[0]} : 32'hDEAD,
        32'hF0);
    chk("nack_stops", n_stop, 32'd1);
    chk("nack_end_pulses", n_end, 32'd1);
    nack_mode = 1'b0;
`endif

    mon_clear();
    wr_en = 1'b1; rd_en = 1'b0; addr_num = 1'b0;
    byte_addr = 16'h0034; wr_data = 8'h3C;
    i2c_start = 1'b1;
    k = 0;
    while (dut.state != 4'd8 && k < 8000) begin
      @(negedge sys_clk);
      k++;
    end
    chk("rst_reach_wr_data", {28'd0, dut.state}, 32'd8);
    repeat (300) @(negedge sys_clk);
    chk("pre_rst_drive", {31'd0, dut.sda_en}, 32'd1);
    sys_rst_n = 1'b0;
    i2c_start = 1'b0;
    #50;
    chk("mid_rst_scl", {31'd0, i2c_scl}, 32'd1);
    chk("mid_rst_sda_rel", {31'd0, dut.sda_en}, 32'd0);
    chk("mid_rst_state", {28'd0, dut.state}, 32'd0);
    chk("mid_rst_end", {31'd0, i2c_end}, 32'd0);
    chk("mid_rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("mid_rst_i2c_clk", {31'd0, i2c_clk}, 32'd1);
    sys_rst_n = 1'b1;
    repeat (500) @(negedge sys_clk);
    chk("post_rst_state", {28'd0, dut.state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
